// File: rtl/aria_pkg.sv
// Shared ARIA definitions: key-size codes, round counts, key-schedule
// rotation amounts and 128-bit rotate helpers.
package aria_pkg;

    typedef enum logic [1:0] {
        KSIZE_UNSET = 2'b00,
        KSIZE_128   = 2'b01,
        KSIZE_192   = 2'b10,
        KSIZE_256   = 2'b11
    } ksize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EMIT = 2'b10
    } rkg_state_e;

    localparam int ROT_19 = 19;
    localparam int ROT_31 = 31;
    localparam int ROT_61 = 61;

    // Number of rounds for a key-size code; 0 for the unset code.
    function automatic logic [4:0] nr_of(input logic [1:0] ksize);
        logic [4:0] nr;
        case (ksize)
            KSIZE_128: nr = 5'd12;
            KSIZE_192: nr = 5'd14;
            KSIZE_256: nr = 5'd16;
            default:   nr = 5'd0;
        endcase
        return nr;
    endfunction

    function automatic logic [127:0] rotr128(input logic [127:0] x, input int n);
        return (x >> n) | (x << (128 - n));
    endfunction

    function automatic logic [127:0] rotl128(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction

endpackage

// File: rtl/aria_rkey_gen_if.sv
// Round-key stream from the key generator to the round datapath.
interface aria_rkey_gen_if #(
    parameter int KW    = 128,
    parameter int IDX_W = 5
);
    logic [KW-1:0]    rkey;
    logic             rkey_valid;
    logic             rkey_ready;
    logic [IDX_W-1:0] rkey_idx;
    logic             rkey_last;

    modport master (
        output rkey,
        output rkey_valid,
        output rkey_idx,
        output rkey_last,
        input  rkey_ready
    );

    modport slave (
        input  rkey,
        input  rkey_valid,
        input  rkey_idx,
        input  rkey_last,
        output rkey_ready
    );
endinterface

// File: rtl/aria_diff.sv
// ARIA diffusion layer A: a fixed 16x16 binary matrix over bytes, byte 0
// being the most significant. Purely combinational; also used by the
// round datapath.
module aria_diff (
    input  logic [127:0] x,
    output logic [127:0] y
);
    logic [7:0] b [16];

    // Split the input into bytes, b[0] = x[127:120].
    for (genvar i = 0; i < 16; i++) begin : g_split
        assign b[i] = x[127 - 8*i -: 8];
    end

    assign y = {
        b[3] ^ b[4] ^ b[6]  ^ b[8]  ^ b[9]  ^ b[13] ^ b[14],
        b[2] ^ b[5] ^ b[7]  ^ b[8]  ^ b[9]  ^ b[12] ^ b[15],
        b[1] ^ b[4] ^ b[6]  ^ b[10] ^ b[11] ^ b[12] ^ b[15],
        b[0] ^ b[5] ^ b[7]  ^ b[10] ^ b[11] ^ b[13] ^ b[14],
        b[0] ^ b[2] ^ b[5]  ^ b[8]  ^ b[11] ^ b[14] ^ b[15],
        b[1] ^ b[3] ^ b[4]  ^ b[9]  ^ b[10] ^ b[14] ^ b[15],
        b[0] ^ b[2] ^ b[7]  ^ b[9]  ^ b[10] ^ b[12] ^ b[13],
        b[1] ^ b[3] ^ b[6]  ^ b[8]  ^ b[11] ^ b[12] ^ b[13],
        b[0] ^ b[1] ^ b[4]  ^ b[7]  ^ b[10] ^ b[13] ^ b[15],
        b[0] ^ b[1] ^ b[5]  ^ b[6]  ^ b[11] ^ b[12] ^ b[14],
        b[2] ^ b[3] ^ b[5]  ^ b[6]  ^ b[8]  ^ b[13] ^ b[15],
        b[2] ^ b[3] ^ b[4]  ^ b[7]  ^ b[9]  ^ b[12] ^ b[14],
        b[1] ^ b[2] ^ b[6]  ^ b[7]  ^ b[9]  ^ b[11] ^ b[12],
        b[0] ^ b[3] ^ b[6]  ^ b[7]  ^ b[8]  ^ b[10] ^ b[13],
        b[0] ^ b[3] ^ b[4]  ^ b[5]  ^ b[9]  ^ b[11] ^ b[14],
        b[1] ^ b[2] ^ b[4]  ^ b[5]  ^ b[8]  ^ b[10] ^ b[15]
    };
endmodule

// File: rtl/aria_rkey_gen.sv
// ARIA round-key generator: snapshots W0..W3 on start and streams the
// Nr+1 round keys (encryption or decryption order) over valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; start with unset key size pulses err
// LOAD    | snapshot taken, key 1 computed and registered this cycle
// EMIT    | presenting rkey; advance on handshake, leave after key Nr+1
module aria_rkey_gen
    import aria_pkg::*;
#(
    parameter int KW    = 128,
    parameter int IDX_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dec,
    input  logic          clr,
    input  logic [1:0]    st_ksize,
    input  logic [KW-1:0] w0,
    input  logic [KW-1:0] w1,
    input  logic [KW-1:0] w2,
    input  logic [KW-1:0] w3,
    aria_rkey_gen_if.master rk,
    output logic          busy,
    output logic          err
);

    rkg_state_e       state;
    logic [KW-1:0]    snap_w [4];
    logic             snap_dec;
    logic [IDX_W-1:0] snap_nr;

    logic [KW-1:0]    rkey_q;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;

    logic [IDX_W-1:0] nr_p1;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] src_m1;
    logic [1:0]       pos;
    logic [1:0]       pos_n;
    logic [IDX_W-3:0] grp;
    logic [KW-1:0]    wa;
    logic [KW-1:0]    wb_rot;
    logic [KW-1:0]    ek;
    logic [KW-1:0]    ek_diff;
    logic             use_diff;
    logic [KW-1:0]    next_key;
    logic             hs;

    assign nr_p1    = snap_nr + IDX_W'(1);
    assign next_idx = (state == ST_LOAD) ? IDX_W'(1) : idx_q + IDX_W'(1);
    assign hs       = valid_q && rk.rkey_ready;

    // Map the output position to the encryption key it is built from;
    // decryption walks the encryption keys backwards.
    always_comb begin
        src = next_idx;
        if (snap_dec) begin
            if (next_idx == IDX_W'(1)) begin
                src = nr_p1;
            end else if (next_idx == nr_p1) begin
                src = IDX_W'(1);
            end else begin
                src = nr_p1 + IDX_W'(1) - next_idx;
            end
        end
    end

    // ek_i = W(p) ^ rot(W(p+1)), p = (i-1) mod 4, rotation chosen by (i-1)/4.
    // Key 17 lands in group 4 with p = 0, which is exactly W0 ^ (W1 <<< 19).
    assign src_m1 = src - IDX_W'(1);
    assign pos    = src_m1[1:0];
    assign pos_n  = pos + 2'd1;
    assign grp    = src_m1[IDX_W-1:2];
    assign wa     = snap_w[pos];

    // Rotation of the second word for the selected key group.
    always_comb begin
        wb_rot = '0;
        case (grp)
            3'd0:    wb_rot = rotr128(snap_w[pos_n], ROT_19);
            3'd1:    wb_rot = rotr128(snap_w[pos_n], ROT_31);
            3'd2:    wb_rot = rotl128(snap_w[pos_n], ROT_61);
            3'd3:    wb_rot = rotl128(snap_w[pos_n], ROT_31);
            default: wb_rot = rotl128(snap_w[pos_n], ROT_19);
        endcase
    end

    assign ek = wa ^ wb_rot;

    aria_diff u_diff (
        .x (ek),
        .y (ek_diff)
    );

    // First and last decryption keys are used as-is; the middle ones get A.
    assign use_diff = snap_dec && (next_idx != IDX_W'(1)) && (next_idx != nr_p1);
    assign next_key = use_diff ? ek_diff : ek;

    // Sequencer: snapshot, key counter and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            snap_w[0] <= '0;
            snap_w[1] <= '0;
            snap_w[2] <= '0;
            snap_w[3] <= '0;
            snap_dec <= 1'b0;
            snap_nr  <= '0;
            rkey_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr) begin
                state    <= ST_IDLE;
                snap_w[0] <= '0;
                snap_w[1] <= '0;
                snap_w[2] <= '0;
                snap_w[3] <= '0;
                snap_dec <= 1'b0;
                snap_nr  <= '0;
                rkey_q   <= '0;
                valid_q  <= 1'b0;
                idx_q    <= '0;
                last_q   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (st_ksize == KSIZE_UNSET) begin
                                err <= 1'b1;
                            end else begin
                                snap_w[0] <= w0;
                                snap_w[1] <= w1;
                                snap_w[2] <= w2;
                                snap_w[3] <= w3;
                                snap_dec  <= dec;
                                snap_nr   <= IDX_W'(nr_of(st_ksize));
                                busy      <= 1'b1;
                                state     <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        rkey_q  <= next_key;
                        idx_q   <= next_idx;
                        last_q  <= (next_idx == nr_p1);
                        valid_q <= 1'b1;
                        state   <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (hs) begin
                            if (idx_q == nr_p1) begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy    <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                rkey_q <= next_key;
                                idx_q  <= next_idx;
                                last_q <= (next_idx == nr_p1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rk.rkey       = rkey_q;
    assign rk.rkey_valid = valid_q;
    assign rk.rkey_idx   = idx_q;
    assign rk.rkey_last  = last_q;

endmodule

// File: tb/tb_aria_rkey_gen.sv
// Directed bench for aria_rkey_gen: key order, stalls, abort and reset.
module tb_aria_rkey_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dec;
    logic         clr;
    logic [1:0]   st_ksize;
    logic [127:0] w0, w1, w2, w3;
    logic         busy;
    logic         err;

    aria_rkey_gen_if #(.KW(128), .IDX_W(5)) rk_if ();

    aria_rkey_gen #(.KW(128), .IDX_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dec      (dec),
        .clr      (clr),
        .st_ksize (st_ksize),
        .w0       (w0),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .rk       (rk_if),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [127:0] tw [4];
    logic [127:0] obs_key  [32];
    logic [4:0]   obs_idx  [32];
    logic         obs_last [32];
    int           n_obs;
    int           first_valid;
    bit           timed_out;

    function automatic logic [127:0] ror(input logic [127:0] x, input int n);
        return (x >> n) | (x << (128 - n));
    endfunction

    function automatic logic [127:0] rol(input logic [127:0] x, input int n);
        return ror(x, 128 - n);
    endfunction

    function automatic logic [127:0] ek_model(input int i);
        case (i)
            1:  return tw[0] ^ ror(tw[1], 19);
            2:  return tw[1] ^ ror(tw[2], 19);
            3:  return tw[2] ^ ror(tw[3], 19);
            4:  return tw[3] ^ ror(tw[0], 19);
            5:  return tw[0] ^ ror(tw[1], 31);
            6:  return tw[1] ^ ror(tw[2], 31);
            7:  return tw[2] ^ ror(tw[3], 31);
            8:  return tw[3] ^ ror(tw[0], 31);
            9:  return tw[0] ^ rol(tw[1], 61);
            10: return tw[1] ^ rol(tw[2], 61);
            11: return tw[2] ^ rol(tw[3], 61);
            12: return tw[3] ^ rol(tw[0], 61);
            13: return tw[0] ^ rol(tw[1], 31);
            14: return tw[1] ^ rol(tw[2], 31);
            15: return tw[2] ^ rol(tw[3], 31);
            16: return tw[3] ^ rol(tw[0], 31);
            17: return tw[0] ^ rol(tw[1], 19);
            default: return '0;
        endcase
    endfunction

    function automatic logic [127:0] a_model(input logic [127:0] x);
        logic [7:0]   xb [16];
        int           t [7];
        logic [7:0]   acc;
        logic [127:0] y;
        for (int i = 0; i < 16; i++) xb[i] = x[127 - 8*i -: 8];
        y = '0;
        for (int j = 0; j < 16; j++) begin
            case (j)
                0:  t = '{3, 4, 6, 8, 9, 13, 14};
                1:  t = '{2, 5, 7, 8, 9, 12, 15};
                2:  t = '{1, 4, 6, 10, 11, 12, 15};
                3:  t = '{0, 5, 7, 10, 11, 13, 14};
                4:  t = '{0, 2, 5, 8, 11, 14, 15};
                5:  t = '{1, 3, 4, 9, 10, 14, 15};
                6:  t = '{0, 2, 7, 9, 10, 12, 13};
                7:  t = '{1, 3, 6, 8, 11, 12, 13};
                8:  t = '{0, 1, 4, 7, 10, 13, 15};
                9:  t = '{0, 1, 5, 6, 11, 12, 14};
                10: t = '{2, 3, 5, 6, 8, 13, 15};
                11: t = '{2, 3, 4, 7, 9, 12, 14};
                12: t = '{1, 2, 6, 7, 9, 11, 12};
                13: t = '{0, 3, 6, 7, 8, 10, 13};
                14: t = '{0, 3, 4, 5, 9, 11, 14};
                default: t = '{1, 2, 4, 5, 8, 10, 15};
            endcase
            acc = 8'h00;
            for (int k = 0; k < 7; k++) acc = acc ^ xb[t[k]];
            y[127 - 8*j -: 8] = acc;
        end
        return y;
    endfunction

    function automatic logic [127:0] dk_model(input int i, input int nr);
        if (i == 1)      return ek_model(nr + 1);
        if (i == nr + 1) return ek_model(1);
        return a_model(ek_model(nr + 2 - i));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] c, input logic [127:0] d);
        tw[0] = a; tw[1] = b; tw[2] = c; tw[3] = d;
        w0 = a; w1 = b; w2 = c; w3 = d;
    endtask

    task automatic pulse_start(input logic [1:0] ks, input logic d);
        st_ksize = ks;
        dec      = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Record every accepted key until the last one is handed over.
    task automatic collect(input int budget);
        bit done;
        done = 0; n_obs = 0; timed_out = 0; first_valid = -1;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (rk_if.rkey_valid && first_valid < 0) first_valid = c;
            if (rk_if.rkey_valid && rk_if.rkey_ready) begin
                if (n_obs < 32) begin
                    obs_key[n_obs]  = rk_if.rkey;
                    obs_idx[n_obs]  = rk_if.rkey_idx;
                    obs_last[n_obs] = rk_if.rkey_last;
                end
                n_obs++;
                if (rk_if.rkey_last) begin
                    tick();
                    done = 1;
                end
            end
        end
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dec = 1'b0; clr = 1'b0; st_ksize = 2'b00;
        rk_if.rkey_ready = 1'b0;
        set_w('0, '0, '0, '0);
        tick(); tick();
        rst = 1'b0;
        checks++; if (rk_if.rkey !== 128'h0) begin errors++; $display("FAIL reset_rkey: got %h want 0", rk_if.rkey); end
        checks++; if (rk_if.rkey_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rk_if.rkey_valid); end
        checks++; if (rk_if.rkey_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", rk_if.rkey_idx); end
        checks++; if (rk_if.rkey_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", rk_if.rkey_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    // 128-bit key, encryption order; W0 is the RFC 5794 key bytes, W1 a single
    // set bit so a few keys are simple to work out by hand.
    task automatic test_enc128();
        set_w(128'h000102030405060708090a0b0c0d0e0f,
              128'h00000000000000000000000000080000,
              128'h0123456789abcdeffedcba9876543210,
              128'hdeadbeefcafebabe0badf00dfeedface);
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b01, 1'b0);
        checks++; if (rk_if.rkey_valid !== 1'b0) begin errors++; $display("FAIL enc128_early_valid: got %b want 0", rk_if.rkey_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc128_busy_on: got %b want 1", busy); end
        collect(40);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL enc128_timeout: got %b want 0", timed_out); end
        checks++; if (first_valid !== 0) begin errors++; $display("FAIL enc128_latency: got %0d want 0", first_valid); end
        checks++; if (n_obs !== 13) begin errors++; $display("FAIL enc128_count: got %0d want 13", n_obs); end
        for (int i = 0; i < 13 && i < n_obs; i++) begin
            checks++; if (obs_key[i] !== ek_model(i + 1)) begin errors++; $display("FAIL enc128_key%0d: got %h want %h", i + 1, obs_key[i], ek_model(i + 1)); end
            checks++; if (obs_idx[i] !== 5'(i + 1)) begin errors++; $display("FAIL enc128_idx%0d: got %0d want %0d", i + 1, obs_idx[i], i + 1); end
            checks++; if (obs_last[i] !== (i == 12)) begin errors++; $display("FAIL enc128_last%0d: got %b want %b", i + 1, obs_last[i], (i == 12)); end
        end
        checks++; if (obs_key[0] !== 128'h000102030405060708090a0b0c0d0e0e) begin errors++; $display("FAIL enc128_ek1_hand: got %h want 000102030405060708090a0b0c0d0e0e", obs_key[0]); end
        checks++; if (obs_key[4] !== 128'h001102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL enc128_ek5_hand: got %h want 001102030405060708090a0b0c0d0e0f", obs_key[4]); end
        checks++; if (obs_key[8] !== 128'h000102030404060708090a0b0c0d0e0f) begin errors++; $display("FAIL enc128_ek9_hand: got %h want 000102030404060708090a0b0c0d0e0f", obs_key[8]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enc128_busy_off: got %b want 0", busy); end
        checks++; if (rk_if.rkey_valid !== 1'b0) begin errors++; $display("FAIL enc128_valid_off: got %b want 0", rk_if.rkey_valid); end
    endtask

    // 256-bit key: encryption run for all 17 keys, then decryption order.
    task automatic test_dec256();
        set_w(128'h00112233445566778899aabbccddeeff,
              128'hf0e1d2c3b4a5968778695a4b3c2d1e0f,
              128'h13579bdf02468ace1122334455667788,
              128'h8badf00ddeadc0de0123456789abcdef);
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b11, 1'b0);
        collect(60);
        checks++; if (n_obs !== 17 || timed_out) begin errors++; $display("FAIL enc256_count: got %0d want 17 (timeout %b)", n_obs, timed_out); end
        for (int i = 0; i < 17 && i < n_obs; i++) begin
            checks++; if (obs_key[i] !== ek_model(i + 1)) begin errors++; $display("FAIL enc256_key%0d: got %h want %h", i + 1, obs_key[i], ek_model(i + 1)); end
        end
        pulse_start(2'b11, 1'b1);
        collect(60);
        checks++; if (n_obs !== 17 || timed_out) begin errors++; $display("FAIL dec256_count: got %0d want 17 (timeout %b)", n_obs, timed_out); end
        for (int i = 0; i < 17 && i < n_obs; i++) begin
            checks++; if (obs_key[i] !== dk_model(i + 1, 16)) begin errors++; $display("FAIL dec256_key%0d: got %h want %h", i + 1, obs_key[i], dk_model(i + 1, 16)); end
            checks++; if (obs_idx[i] !== 5'(i + 1)) begin errors++; $display("FAIL dec256_idx%0d: got %0d want %0d", i + 1, obs_idx[i], i + 1); end
            checks++; if (obs_last[i] !== (i == 16)) begin errors++; $display("FAIL dec256_last%0d: got %b want %b", i + 1, obs_last[i], (i == 16)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec256_busy_off: got %b want 0", busy); end
    endtask

    // 192-bit key with the consumer stalling three cycles on key 5.
    task automatic test_stall192();
        bit done;
        int stall;
        set_w(128'hcafef00d000000001111111122222222,
              128'h0f0f0f0ff0f0f0f05555aaaa3333cccc,
              128'h76543210fedcba980011223344556677,
              128'h89abcdef01234567deadbeef00000001);
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b10, 1'b0);
        done = 0; stall = 0; n_obs = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (rk_if.rkey_valid && rk_if.rkey_idx == 5'd5 && stall < 3) begin
                if (stall > 0) begin
                    checks++; if (rk_if.rkey !== ek_model(5)) begin errors++; $display("FAIL stall_key_hold: got %h want %h", rk_if.rkey, ek_model(5)); end
                    checks++; if (rk_if.rkey_idx !== 5'd5) begin errors++; $display("FAIL stall_idx_hold: got %0d want 5", rk_if.rkey_idx); end
                end
                rk_if.rkey_ready = 1'b0;
                stall++;
            end else begin
                rk_if.rkey_ready = 1'b1;
                if (rk_if.rkey_valid) begin
                    if (n_obs < 32) begin
                        obs_key[n_obs] = rk_if.rkey;
                        obs_idx[n_obs] = rk_if.rkey_idx;
                    end
                    n_obs++;
                    if (rk_if.rkey_last) begin
                        tick();
                        done = 1;
                    end
                end
            end
        end
        rk_if.rkey_ready = 1'b1;
        checks++; if (stall !== 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", stall); end
        checks++; if (n_obs !== 15 || !done) begin errors++; $display("FAIL stall_count: got %0d want 15 (done %b)", n_obs, done); end
        for (int i = 0; i < 15 && i < n_obs; i++) begin
            checks++; if (obs_key[i] !== ek_model(i + 1) || obs_idx[i] !== 5'(i + 1)) begin errors++; $display("FAIL stall_key%0d: got %h idx %0d want %h idx %0d", i + 1, obs_key[i], obs_idx[i], ek_model(i + 1), i + 1); end
        end
    endtask

    task automatic test_err_unset();
        bit seen_valid;
        bit seen_busy;
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b00, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b want 0", busy); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width: got %b want 0", err); end
        seen_valid = 0; seen_busy = 0;
        for (int c = 0; c < 6; c++) begin
            if (rk_if.rkey_valid) seen_valid = 1;
            if (busy) seen_busy = 1;
            tick();
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL err_no_valid: got %b want 0", seen_valid); end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL err_no_busy: got %b want 0", seen_busy); end
    endtask

    task automatic test_clr_abort();
        bit found;
        set_w(128'h000102030405060708090a0b0c0d0e0f,
              128'h00000000000000000000000000080000,
              128'h0123456789abcdeffedcba9876543210,
              128'hdeadbeefcafebabe0badf00dfeedface);
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b01, 1'b0);
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (rk_if.rkey_valid && rk_if.rkey_idx == 5'd7) found = 1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL clr_reach_idx7: got %b want 1", found); end
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        checks++; if (rk_if.rkey_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", rk_if.rkey_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
        checks++; if (rk_if.rkey !== 128'h0) begin errors++; $display("FAIL clr_rkey: got %h want 0", rk_if.rkey); end
        tick(); tick(); tick();
        checks++; if (rk_if.rkey_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr_start_ignored: valid %b busy %b want 0 0", rk_if.rkey_valid, busy); end
        pulse_start(2'b01, 1'b0);
        collect(40);
        checks++; if (n_obs !== 13 || timed_out) begin errors++; $display("FAIL clr_restart_count: got %0d want 13", n_obs); end
        checks++; if (obs_idx[0] !== 5'd1 || obs_key[0] !== ek_model(1)) begin errors++; $display("FAIL clr_restart_first: got idx %0d key %h want idx 1 key %h", obs_idx[0], obs_key[0], ek_model(1)); end
        checks++; if (obs_key[12] !== ek_model(13)) begin errors++; $display("FAIL clr_restart_last: got %h want %h", obs_key[12], ek_model(13)); end
    endtask

    task automatic test_rst_snapshot();
        bit found;
        set_w(128'h11111111222222223333333344444444,
              128'h55555555666666667777777788888888,
              128'h9999999aaaaaaaabbbbbbbbccccccccd,
              128'heeeeeeeeffffffff0000000012345678);
        rk_if.rkey_ready = 1'b1;
        pulse_start(2'b01, 1'b0);
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (rk_if.rkey_valid && rk_if.rkey_idx == 5'd4) found = 1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_idx4: got %b want 1", found); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({rk_if.rkey, rk_if.rkey_valid, rk_if.rkey_idx, rk_if.rkey_last, busy, err} !== '0) begin errors++; $display("FAIL rst_outputs: rkey %h valid %b idx %0d last %b busy %b err %b want all 0", rk_if.rkey, rk_if.rkey_valid, rk_if.rkey_idx, rk_if.rkey_last, busy, err); end
        set_w(128'h0badc0de0badc0de0badc0de0badc0de,
              128'h12345678123456781234567812345678,
              128'hfedcba98fedcba98fedcba98fedcba98,
              128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        pulse_start(2'b01, 1'b0);
        w0 = ~tw[0];
        st_ksize = 2'b11;
        collect(40);
        w0 = tw[0];
        checks++; if (n_obs !== 13 || timed_out) begin errors++; $display("FAIL snap_count: got %0d want 13", n_obs); end
        for (int i = 0; i < 13 && i < n_obs; i++) begin
            checks++; if (obs_key[i] !== ek_model(i + 1)) begin errors++; $display("FAIL snap_key%0d: got %h want %h", i + 1, obs_key[i], ek_model(i + 1)); end
        end
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_dec256();
        test_stall192();
        test_err_unset();
        test_clr_abort();
        test_rst_snapshot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
